// File: rtl/button_event_arbiter.sv
// Button event arbiter: turns debounced press edges into per-button pending events and
// presents them one at a time, round-robin, on a valid/ready port.
// Long-press events are compiled in only when `BUTTON_LONG_PRESS_EN is defined.
module button_event_arbiter #(
   parameter int N_BTN         = 4,
   parameter int CLK_FREQ_MHZ  = 50,
   parameter int LONG_PRESS_MS = 1000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_BTN-1:0]         btn_db,
   input  logic                     evt_ready,
   output logic                     evt_valid,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic                     evt_long,
   output logic [N_BTN-1:0]         pending,
   output logic                     drop
);
   localparam int IDW = $clog2(N_BTN);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t           state_q;
   logic [N_BTN-1:0] prev_q;
   logic [N_BTN-1:0] pending_q;
   logic [N_BTN-1:0] pending_d;
   logic [N_BTN-1:0] pressEdge;
   logic [N_BTN-1:0] clrShort;
   logic [N_BTN-1:0] req;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   evtId_q;
   logic [IDW-1:0]   winId;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   ptrNext;
   logic             evtValid_q;
   logic             evtLong_q;
   logic             drop_q;
   logic             drop_d;
   logic             found;
   logic             winLong;
   logic             accept;
   logic             dropLong;
   int               idx;

`ifdef BUTTON_LONG_PRESS_EN
   localparam int LONG_CYCLES = LONG_PRESS_MS * CLK_FREQ_MHZ * 1000;
   localparam int CW          = $clog2(LONG_CYCLES + 1);

   logic [CW-1:0]    holdCnt_q [N_BTN];
   logic [CW-1:0]    holdCnt_d [N_BTN];
   logic [N_BTN-1:0] longPending_q;
   logic [N_BTN-1:0] longPending_d;
   logic [N_BTN-1:0] longHit;
   logic [N_BTN-1:0] clrLong;

   // The hold counter saturates, so the LONG_CYCLES-1 -> LONG_CYCLES step fires once per press.
   always_comb begin
      clrLong = '0;
      if (accept && evtLong_q) clrLong[evtId_q] = 1'b1;
      for (int i = 0; i < N_BTN; i++) begin
         longHit[i] = btn_db[i] && (holdCnt_q[i] == CW'(LONG_CYCLES - 1));
         if (!btn_db[i])
            holdCnt_d[i] = '0;
         else if (holdCnt_q[i] == CW'(LONG_CYCLES))
            holdCnt_d[i] = holdCnt_q[i];
         else
            holdCnt_d[i] = holdCnt_q[i] + 1'b1;
      end
      longPending_d = (longPending_q & ~clrLong) | longHit;
      dropLong      = |(longHit & longPending_q & ~clrLong);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         longPending_q <= '0;
         for (int i = 0; i < N_BTN; i++) holdCnt_q[i] <= '0;
      end else begin
         longPending_q <= longPending_d;
         for (int i = 0; i < N_BTN; i++) holdCnt_q[i] <= holdCnt_d[i];
      end
   end

   assign req      = pending_q | longPending_q;
   assign winLong  = ~pending_q[winId];
   assign evt_long = evtLong_q;
`else
   assign req      = pending_q;
   assign winLong  = 1'b0;
   assign dropLong = 1'b0;
   assign evt_long = 1'b0;
`endif

   // A press edge always wins over a same-cycle clear, so a re-press during accept is kept.
   always_comb begin
      pressEdge = btn_db & ~prev_q;
      accept    = evtValid_q & evt_ready;
      clrShort  = '0;
      if (accept && !evtLong_q) clrShort[evtId_q] = 1'b1;
      pending_d = (pending_q & ~clrShort) | pressEdge;
      drop_d    = (|(pressEdge & pending_q & ~clrShort)) | dropLong;

      found = 1'b0;
      winId = '0;
      cand  = '0;
      idx   = 0;
      for (int off = 0; off < N_BTN; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= N_BTN) idx = idx - N_BTN;
         cand = IDW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            winId = cand;
         end
      end
      ptrNext = (evtId_q == IDW'(N_BTN - 1)) ? '0 : evtId_q + 1'b1;
   end

   // prev resets to all ones so a button held through reset release produces no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prev_q     <= '1;
         pending_q  <= '0;
         ptr_q      <= '0;
         evtId_q    <= '0;
         evtValid_q <= 1'b0;
         evtLong_q  <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         prev_q    <= btn_db;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_q    <= PRESENT;
                  evtValid_q <= 1'b1;
                  evtId_q    <= winId;
                  evtLong_q  <= winLong;
               end
            end
            PRESENT: begin
               if (evt_ready) begin
                  state_q    <= IDLE;
                  evtValid_q <= 1'b0;
                  ptr_q      <= ptrNext;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign evt_valid = evtValid_q;
   assign evt_id    = evtId_q;
   assign pending   = pending_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter (4 buttons).
// The long-press scenario runs only when BUTTON_LONG_PRESS_EN is defined.
module tb_button_event_arbiter;
   logic       clk;
   logic       rst_n;
   logic [3:0] btn_db;
   logic       evt_ready;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_long;
   logic [3:0] pending;
   logic       drop;

   int checks;
   int errors;

   button_event_arbiter #(
      .N_BTN         (4),
      .CLK_FREQ_MHZ  (1),
      .LONG_PRESS_MS (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_db    (btn_db),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_long  (evt_long),
      .pending   (pending),
      .drop      (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] btn, input logic rdy);
      btn_db    = btn;
      evt_ready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Checks presented event and pending state together after a clock edge.
   task automatic checkEvent(input string tag, input logic v, input logic [1:0] id, input logic [3:0] pend);
      checkOutput({tag, ".valid"}, 32'(evt_valid), 32'(v));
      if (v) checkOutput({tag, ".id"}, 32'(evt_id), 32'(id));
      checkOutput({tag, ".pending"}, 32'(pending), 32'(pend));
   endtask

   initial begin
      int shortCount;
      int longCount;
      int shortAt;
      int longAt;
      int dropSeen;
      checks = 0;
      errors = 0;

      rst_n = 1'b0;
      applyStimulus(4'b0001, 1'b0);
      #2;
      tick();
      tick();
      checkOutput("reset.valid", 32'(evt_valid), 32'd0);
      checkOutput("reset.pending", 32'(pending), 32'd0);
      checkOutput("reset.drop", 32'(drop), 32'd0);
      checkOutput("reset.id", 32'(evt_id), 32'd0);
      checkOutput("reset.long", 32'(evt_long), 32'd0);

      // Button 0 held through reset release must not produce an event.
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkEvent("heldThroughReset", 1'b0, 2'd0, 4'b0000);
      end
      applyStimulus(4'b0000, 1'b0);
      tick();
      tick();
      applyStimulus(4'b0001, 1'b0);
      tick();
      checkEvent("press0.k", 1'b0, 2'd0, 4'b0001);
      tick();
      checkEvent("press0.k1", 1'b1, 2'd0, 4'b0001);
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkEvent("press0.accept", 1'b0, 2'd0, 4'b0000);

      // Buttons 1 and 3 together, ptr starts at 1: serve 1 then 3.
      applyStimulus(4'b1010, 1'b1);
      tick();
      checkEvent("rr13.set", 1'b0, 2'd0, 4'b1010);
      tick();
      checkEvent("rr13.first", 1'b1, 2'd1, 4'b1010);
      checkOutput("rr13.first.long", 32'(evt_long), 32'd0);
      tick();
      checkEvent("rr13.gap", 1'b0, 2'd0, 4'b1000);
      tick();
      checkEvent("rr13.second", 1'b1, 2'd3, 4'b1000);
      tick();
      checkEvent("rr13.done", 1'b0, 2'd0, 4'b0000);
      applyStimulus(4'b0000, 1'b1);
      tick();

      // ptr wrapped to 0: buttons 0 and 2 together serve 0 first.
      applyStimulus(4'b0101, 1'b1);
      tick();
      checkEvent("rr02.set", 1'b0, 2'd0, 4'b0101);
      tick();
      checkEvent("rr02.first", 1'b1, 2'd0, 4'b0101);
      tick();
      tick();
      checkEvent("rr02.second", 1'b1, 2'd2, 4'b0100);
      tick();
      checkEvent("rr02.done", 1'b0, 2'd0, 4'b0000);
      applyStimulus(4'b0000, 1'b0);
      tick();

      // Stall with evt_ready=0, second press on button 2 is dropped.
      applyStimulus(4'b0100, 1'b0);
      tick();
      applyStimulus(4'b0000, 1'b0);
      tick();
      checkEvent("stall.present", 1'b1, 2'd2, 4'b0100);
      applyStimulus(4'b0100, 1'b0);
      tick();
      checkEvent("stall.repress", 1'b1, 2'd2, 4'b0100);
      checkOutput("stall.dropPulse", 32'(drop), 32'd1);
      tick();
      checkOutput("stall.dropEnd", 32'(drop), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkEvent("stall.hold", 1'b1, 2'd2, 4'b0100);
         checkOutput("stall.noDrop", 32'(drop), 32'd0);
      end
      applyStimulus(4'b0100, 1'b1);
      tick();
      checkEvent("stall.accept", 1'b0, 2'd0, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkEvent("stall.onlyOne", 1'b0, 2'd0, 4'b0000);
      end
      applyStimulus(4'b0000, 1'b0);
      tick();

      // Press edge on button 2 in the same cycle its event is accepted.
      applyStimulus(4'b0100, 1'b0);
      tick();
      applyStimulus(4'b0000, 1'b0);
      tick();
      checkEvent("coinc.present", 1'b1, 2'd2, 4'b0100);
      applyStimulus(4'b0100, 1'b1);
      tick();
      checkEvent("coinc.accept", 1'b0, 2'd0, 4'b0100);
      checkOutput("coinc.drop", 32'(drop), 32'd0);
      tick();
      checkEvent("coinc.second", 1'b1, 2'd2, 4'b0100);
      checkOutput("coinc.drop2", 32'(drop), 32'd0);
      tick();
      checkEvent("coinc.done", 1'b0, 2'd0, 4'b0000);
      applyStimulus(4'b0000, 1'b0);
      tick();

      // Reset in the middle of PRESENT clears outputs asynchronously, no replay.
      applyStimulus(4'b0010, 1'b0);
      tick();
      tick();
      checkEvent("midReset.present", 1'b1, 2'd1, 4'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midReset.valid", 32'(evt_valid), 32'd0);
      checkOutput("midReset.pending", 32'(pending), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkEvent("midReset.noReplay", 1'b0, 2'd0, 4'b0000);
      end
      applyStimulus(4'b0000, 1'b0);
      tick();
      tick();

`ifdef BUTTON_LONG_PRESS_EN
      // Button 0 held 1500 cycles: short event at cycle 2, long event after 1000 high cycles.
      shortCount = 0;
      longCount  = 0;
      shortAt    = -1;
      longAt     = -1;
      dropSeen   = 0;
      applyStimulus(4'b0001, 1'b1);
      for (int t = 1; t <= 1500; t++) begin
         tick();
         if (drop) dropSeen++;
         if (evt_valid) begin
            if (evt_long) begin
               longCount++;
               longAt = t;
            end else begin
               shortCount++;
               shortAt = t;
            end
            checkOutput("long.id", 32'(evt_id), 32'd0);
         end
      end
      applyStimulus(4'b0000, 1'b1);
      for (int t = 0; t < 20; t++) begin
         tick();
         if (evt_valid) begin
            if (evt_long) longCount++;
            else shortCount++;
         end
         if (drop) dropSeen++;
      end
      checkOutput("long.shortCount", 32'(shortCount), 32'd1);
      checkOutput("long.shortAt", 32'(shortAt), 32'd2);
      checkOutput("long.longCount", 32'(longCount), 32'd1);
      checkOutput("long.longAt", 32'(longAt), 32'd1001);
      checkOutput("long.drop", 32'(dropSeen), 32'd0);
`else
      shortCount = 0;
      longCount  = 0;
      shortAt    = 0;
      longAt     = 0;
      dropSeen   = 0;
      // Without long-press support, a long hold yields just the one short event.
      applyStimulus(4'b0001, 1'b1);
      for (int t = 1; t <= 1100; t++) begin
         tick();
         if (evt_valid) begin
            if (evt_long) longCount++;
            else shortCount++;
         end
      end
      applyStimulus(4'b0000, 1'b1);
      checkOutput("hold.shortCount", 32'(shortCount), 32'd1);
      checkOutput("hold.longCount", 32'(longCount), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter N_BTN, default 4, meaning number of button inputs (2..8).
REQ-002 SHALL have parameter CLK_FREQ_MHZ, default 50, meaning clock frequency in MHz.
REQ-003 SHALL have parameter LONG_PRESS_MS, default 1000, meaning hold time for a long-press event.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port btn_db, input, N_BTN bits, meaning debounced button levels, synchronous to clk, 1 = pressed.
REQ-007 SHALL have port evt_ready, input, 1 bit, meaning the consumer accepts the presented event.
REQ-008 SHALL have port evt_valid, output, 1 bit, meaning an event is presented.
REQ-009 SHALL have port evt_id, output, $clog2(N_BTN) bits, meaning the index of the button owning the presented event.
REQ-010 SHALL have port evt_long, output, 1 bit, meaning the presented event is a long press (0 = short press).
REQ-011 SHALL have port pending, output, N_BTN bits, meaning per-button short-press event pending.
REQ-012 SHALL have port drop, output, 1 bit, meaning a one-cycle pulse when an event is lost.

Function
REQ-013 SHALL register btn_db into prev each cycle; press edge on button i = btn_db[i] & ~prev[i].
REQ-014 SHALL set pending[i] on the clock edge after a press edge on button i.
REQ-015 SHALL pulse drop for one cycle when a press edge arrives while pending[i]=1 and that bit is not being cleared in the same cycle; pending stays 1.
REQ-016 SHALL keep pending[i]=1 when a press edge and an accept of button i's short event coincide (set wins).
REQ-017 SHALL implement FSM IDLE -> PRESENT -> IDLE; IDLE with any request selects a winner, loads evt_id/evt_long, and goes to PRESENT; IDLE with no requests stays.
REQ-018 SHALL select the winner round-robin: first requesting index at or above pointer ptr, wrapping from N_BTN-1 to 0.
REQ-019 SHALL, within one button, serve the short event before the long event when both are pending.
REQ-020 SHALL assert evt_valid only in PRESENT, holding evt_id and evt_long stable until accepted.
REQ-021 SHALL accept when evt_valid & evt_ready: clear the served pending bit, set ptr to (evt_id+1) mod N_BTN, and return to IDLE; evt_valid is 0 in the next cycle.
REQ-022 SHALL give latency: press edge sampled at edge k -> pending[i]=1 after k -> evt_valid=1 after k+1 (with FSM idle and no competing requests).
REQ-023 SHALL allow back-to-back events at most every two cycles (the IDLE cycle is mandatory).

Reset
REQ-024 SHALL on rst_n=0 immediately clear evt_valid, evt_long, evt_id, pending, drop, ptr, and all long-press state; FSM -> IDLE.
REQ-025 SHALL reset prev to all ones, so a button held through reset release produces no event until it is released and pressed again.
REQ-026 SHALL discard an in-flight PRESENT event on reset without replay.

Configuration
REQ-027 SHALL compile long-press detection in only when macro BUTTON_LONG_PRESS_EN is defined.
REQ-028 SHALL, with the macro: use LONG_CYCLES = LONG_PRESS_MS*CLK_FREQ_MHZ*1000; keep a per-button saturating hold counter, cleared while btn_db[i]=0.
REQ-029 SHALL, with the macro: set long_pending[i] exactly once per press, when the counter reaches LONG_CYCLES consecutive high cycles; a repeat while already set pulses drop.
REQ-030 SHALL, without the macro: include no counters or long_pending, and tie evt_long to 0.

Verification
REQ-031 SHALL cover: reset release with btn_db=4'b0001 held -> no evt_valid; release then press btn 0 -> evt_valid=1, evt_id=0 two cycles after the edge.
REQ-032 SHALL cover: buttons 1 and 3 pressed in the same cycle, evt_ready=1 -> events with evt_id 1 then 3; ptr=0 -> 2 -> 0.
REQ-033 SHALL cover: evt_ready=0 for 10 cycles -> evt_valid and evt_id stable; second press edge on the same button -> one drop pulse, and only one event delivered.
REQ-034 SHALL cover: press edge on button 2 in the same cycle its event is accepted -> pending[2]=1 afterwards, a second event is delivered, and drop=0.
REQ-035 SHALL cover, with BUTTON_LONG_PRESS_EN, LONG_PRESS_MS=1, CLK_FREQ_MHZ=1: button 0 held 1500 cycles -> short event, then one long event (evt_long=1) after 1000 high cycles; no further events.
REQ-036 SHALL cover: rst_n asserted low mid-PRESENT -> evt_valid=0 asynchronously and pending=0.
